mem_access: RTL
===============

Name: mem_access

Overview:
- Memory-access stage of the RISC-V pipeline, between execute and write-back.
- Takes the ALU result (effective address or arithmetic result), rs2 store data and decoded control from execute.
- Runs the data-memory req/ack handshake for loads and stores, and presents loaded_value and alu_output to write-back in a registered output slot.
- Stalls execute while a memory transaction is outstanding.

Parameters:
XLEN, 32, datapath width; the block supports only 32.
REG_ADDR_W, 5, width of the destination register index.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  execute presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
alu_output  input  32  ALU result; effective address for loads and stores
store_data  input  32  rs2 value for stores
is_load  input  1  instruction is a load
is_store  input  1  instruction is a store; never set together with is_load
funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
rd  input  5  destination register index
dmem_req  output  1  data-memory request
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  32  word-aligned address (alu_output with bits [1:0] = 0)
dmem_wdata  output  32  lane-replicated store data
dmem_wstrb  output  4  byte-enable strobes
dmem_ack  input  1  memory completes the request (read data valid the same cycle)
dmem_rdata  input  32  read data word
out_valid  output  1  result slot valid toward write-back
out_ready  input  1  write-back consumes the slot
loaded_value  output  32  aligned and extended load data; 0 for non-loads
alu_result_out  output  32  registered alu_output
rd_out  output  5  registered rd
is_load_out  output  1  selects loaded_value in write-back
mem_err  output  1  misaligned access or illegal funct3

Behaviour:
- Reset (asynchronous, active-high): state IDLE; out_valid, dmem_req, dmem_we, mem_err and is_load_out are 0; dmem_wstrb is 0000; all data outputs and rd_out are 0.
- States:
  - IDLE: waiting for an instruction.
  - REQ: dmem_req held high until ack.
  - HOLD: output slot full, waiting for out_ready.
- in_ready = (state == IDLE) and (out_valid == 0 or out_ready == 1).
- A transfer happens when in_valid and in_ready are both 1.
- Non-memory instruction: registered into the output slot next cycle (latency 1), with loaded_value = 0 and mem_err = 0. Next state is IDLE; out_valid stays high until consumed.
- Memory instruction with an error:
  - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - Illegal funct3: 011, 110 or 111. For stores, only 000, 001 and 010 are legal.
  - No dmem request is issued and the store is suppressed.
  - Output slot is filled next cycle with mem_err = 1 and loaded_value = 0.
- Legal memory instruction:
  - Address, data, strobes and control are captured; next state is REQ.
  - dmem_req goes high the cycle after acceptance. addr, we, wdata and wstrb stay stable until the cycle with dmem_ack = 1.
  - On ack: the slot is filled on the same edge, dmem_req drops, next state is HOLD.
  - Minimum latency from acceptance to out_valid is 2 cycles. Each additional cycle without ack adds 1 cycle.
- HOLD → IDLE when out_ready = 1. In IDLE the slot is also consumed on out_ready, which gives back-to-back throughput for non-memory instructions.
- Load extraction (lane = addr[1:0]):
  - LB/LBU select byte lane*8; LB sign-extends, LBU zero-extends.
  - LH/LHU select the upper half if addr[1] = 1, else the lower half; LH sign-extends, LHU zero-extends.
  - LW passes the word through.
- Store strobes:
  - SB: wstrb = 0001 << lane, wdata = {4{byte}}.
  - SH: wstrb = 0011 or 1100, wdata = {2{half}}.
  - SW: wstrb = 1111.
- Strobes are 0000 whenever dmem_req = 0.
- Output slot contents stay stable while out_valid = 1 and out_ready = 0.
- Reset during REQ: dmem_req drops immediately (asynchronous) and the transaction is abandoned. The memory model must ignore an abandoned request.
- dmem_ack outside REQ is ignored.

Decomposition:
- Package riscv_mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum {IDLE, REQ, HOLD};
  - XLEN.
- One combinational sub-module, load_align (inputs rdata, lane, funct3; output 32-bit extended value), shared with the verification reference model.

Test Plan:
- ADD result 0x0000_1234, out_ready = 1 → out_valid the next cycle, alu_result_out = 0x1234, loaded_value = 0, mem_err = 0; a second instruction accepted back-to-back.
- LB addr 0x103, dmem_rdata 0x80AB_CDEF, ack after 3 wait cycles → dmem_addr 0x100, in_ready low throughout, loaded_value 0xFFFF_FF80. The same case with LBU gives 0x0000_0080.
- SH addr 0x202, store_data 0x0000_BEEF → dmem_we = 1, wstrb 1100, wdata 0xBEEF_BEEF, dmem_req held until ack.
- LW addr 0x301 → no dmem_req, out_valid next cycle with mem_err = 1, loaded_value = 0. SW with funct3 = 011 behaves the same, with no write.
- Load completes while out_ready = 0 for 4 cycles → slot contents stable, in_ready = 0, then released on out_ready.
- Assert rst in the REQ state → dmem_req and out_valid drop with no clock edge. After rst deasserts, the state is IDLE, in_ready = 1, and a late dmem_ack is ignored.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the memory-access stage: funct3 encodings,
// FSM states and the store lane/strobe helpers.
package riscv_mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Illegal size/sign encoding or a misaligned access; unsigned sizes are load-only.
    function automatic logic access_error(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic is_store);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_BU:   err = is_store;
            F3_H:    err = lane[0];
            F3_HU:   err = is_store | lane[0];
            F3_W:    err = |lane;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] strb;
        case (f3)
            F3_B:    strb = 4'b0001 << lane;
            F3_H:    strb = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] data);
        logic [XLEN-1:0] w;
        case (f3)
            F3_B:    w = {4{data[7:0]}};
            F3_H:    w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (lane)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = 8'h00;
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    value = {{24{byte_v[7]}}, byte_v};
            F3_BU:   value = {24'h000000, byte_v};
            F3_H:    value = {{16{half_v[15]}}, half_v};
            F3_HU:   value = {16'h0000, half_v};
            F3_W:    value = rdata;
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data-memory reads/writes and holds the
// result for write-back in a single registered output slot.
module mem_access
    import riscv_mem_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_output,
    input  logic [XLEN-1:0]       store_data,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    output logic [3:0]            dmem_wstrb,
    input  logic                  dmem_ack,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       loaded_value,
    output logic [XLEN-1:0]       alu_result_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  is_load_out,
    output logic                  mem_err
);

    // Handshakes: a beat moves on a rising edge where valid and ready are both 1;
    // a producer holds valid and its payload until that edge, and ready never
    // depends on valid.
    state_e          state;
    logic [2:0]      pend_f3;
    logic [XLEN-1:0] aligned;
    logic            accept;
    logic            is_mem;
    logic            acc_err;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = is_load || is_store;
    assign acc_err  = is_mem && access_error(funct3, alu_output[1:0], is_store);

    // alu_result_out carries the in-flight address, so its low bits give the lane.
    load_align u_align (
        .rdata  (dmem_rdata),
        .lane   (alu_result_out[1:0]),
        .funct3 (pend_f3),
        .value  (aligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pend_f3        <= 3'b000;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= 4'b0000;
            out_valid      <= 1'b0;
            loaded_value   <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            is_load_out    <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_valid && out_ready) out_valid <= 1'b0;
                    if (accept) begin
                        alu_result_out <= alu_output;
                        rd_out         <= rd;
                        is_load_out    <= is_load;
                        loaded_value   <= '0;
                        mem_err        <= acc_err;
                        if (is_mem && !acc_err) begin
                            pend_f3    <= funct3;
                            dmem_req   <= 1'b1;
                            dmem_we    <= is_store;
                            dmem_addr  <= {alu_output[XLEN-1:2], 2'b00};
                            dmem_wdata <= is_store ? store_wdata(funct3, store_data) : '0;
                            dmem_wstrb <= is_store ? store_strobe(funct3, alu_output[1:0])
                                                   : 4'b0000;
                            state      <= REQ;
                        end else begin
                            out_valid <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        dmem_wstrb   <= 4'b0000;
                        loaded_value <= is_load_out ? aligned : '0;
                        out_valid    <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
